// File: rtl/ttt_match_sched.sv
// Match sequencer in front of the tic-tac-toe controller: grants the key bus to the
// active player, times turns, detects win/draw/timeout, keeps scores, restarts rounds.
module ttt_match_sched #(
    parameter int unsigned TURN_CYCLES = 250_000_000,
    parameter int unsigned HOLD_CYCLES = 75_000_000,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_scores,
    input  logic [5:0]         p1_keys,
    input  logic [5:0]         p2_keys,
    input  logic               current_player,
    input  logic               win_flag,
    input  logic [17:0]        board_in,
    output logic [5:0]         key_out,
    output logic               game_rst,
    output logic               round_over,
    output logic [1:0]         result,
    output logic               timeout_flag,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [SCORE_W-1:0] score_draw
);
    localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {S_RST, S_PLAY, S_OVER} state_t;

    state_t      state;
    logic [TW-1:0] turn_timer;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rst_cnt;
    logic        lockout;
    logic        prev_player;
    logic [5:0]  prev_keys;
    logic [1:0]  prev_enter;
    logic        draw_seen;

    logic [5:0]  active;
    logic        board_full;
    logic        full_now;
    logic        key_rise;
    logic        player_chg;
    logic        locked;
    logic        enter_rise;
    logic        do_win;
    logic        do_draw;
    logic        do_tout;
    logic        p1_point;
    logic        p2_point;

    always_comb begin
        active     = current_player ? p2_keys : p1_keys;
        board_full = 1'b1;
        for (int unsigned i = 0; i < 9; i++) begin
            if (board_in[2*i +: 2] == 2'b00)
                board_full = 1'b0;
        end
        full_now   = board_full && !win_flag;
        key_rise   = |(active & ~prev_keys);
        player_chg = current_player != prev_player;
        locked     = lockout || player_chg;
        enter_rise = (p1_keys[1] & ~prev_enter[0]) | (p2_keys[1] & ~prev_enter[1]);
        do_win     = (state == S_PLAY) && win_flag;
        do_draw    = (state == S_PLAY) && full_now && draw_seen;
        do_tout    = (state == S_PLAY) && !do_win && !do_draw && (turn_timer == TURN_LAST);
        // A timeout awards the point to the player who was waiting.
        p1_point   = (do_win && !current_player) || (do_tout && current_player);
        p2_point   = (do_win && current_player) || (do_tout && !current_player);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RST;
            turn_timer   <= '0;
            hold_cnt     <= '0;
            rst_cnt      <= '0;
            lockout      <= 1'b0;
            prev_player  <= 1'b0;
            prev_keys    <= '0;
            prev_enter   <= '0;
            draw_seen    <= 1'b0;
            key_out      <= '0;
            game_rst     <= 1'b1;
            round_over   <= 1'b0;
            result       <= 2'b00;
            timeout_flag <= 1'b0;
            score_p1     <= '0;
            score_p2     <= '0;
            score_draw   <= '0;
        end else begin
            prev_player <= current_player;
            prev_keys   <= active;
            prev_enter  <= {p2_keys[1], p1_keys[1]};

            case (state)
                S_RST: begin
                    key_out    <= '0;
                    turn_timer <= '0;
                    lockout    <= 1'b0;
                    draw_seen  <= 1'b0;
                    if (rst_cnt == RST_LAST) begin
                        state    <= S_PLAY;
                        game_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                S_PLAY: begin
                    // Hold the bus at zero after a hand-over until the new player lets go.
                    key_out   <= locked ? '0 : active;
                    if (locked)
                        lockout <= |active;
                    turn_timer <= (player_chg || key_rise) ? '0 : turn_timer + TW'(1);
                    draw_seen  <= full_now;
                    if (do_win || do_draw || do_tout) begin
                        state        <= S_OVER;
                        key_out      <= '0;
                        round_over   <= 1'b1;
                        hold_cnt     <= '0;
                        timeout_flag <= do_tout;
                        if (do_win)
                            result <= current_player ? 2'b10 : 2'b01;
                        else if (do_draw)
                            result <= 2'b11;
                        else
                            result <= current_player ? 2'b01 : 2'b10;
                    end
                end
                S_OVER: begin
                    key_out <= '0;
                    if (enter_rise || hold_cnt == HOLD_LAST) begin
                        state        <= S_RST;
                        game_rst     <= 1'b1;
                        rst_cnt      <= '0;
                        round_over   <= 1'b0;
                        result       <= 2'b00;
                        timeout_flag <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= S_RST;
            endcase

            if (clr_scores) begin
                score_p1   <= '0;
                score_p2   <= '0;
                score_draw <= '0;
            end else begin
                if (p1_point && score_p1 != '1)
                    score_p1 <= score_p1 + SCORE_W'(1);
                if (p2_point && score_p2 != '1)
                    score_p2 <= score_p2 + SCORE_W'(1);
                if (do_draw && score_draw != '1)
                    score_draw <= score_draw + SCORE_W'(1);
            end
        end
    end
endmodule
